// File: rtl/lcg_pkg.sv
// Shared types and helpers for the LCG bit packer: FSM state encoding,
// default geometry constants and a constant-foldable ceil(log2) helper.
package lcg_pkg;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_PACK   = 1'b1
    } state_t;

    localparam int WORD_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    // ceil(log2(n)); returns 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcg_word_fifo.sv
// Synchronous word FIFO. A push while full is accepted only when a pop
// happens on the same edge; head_o reads 0 while the FIFO is empty.
module lcg_word_fifo
    import lcg_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   fill_o,
    output logic [WIDTH-1:0]        head_o
);
    localparam int PTR_W  = clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              do_push, do_pop;

    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == FILL_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        fill_d = fill_q;
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fill_q <= fill_d;
        end
    end

    // storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign fill_o = fill_q;

endmodule

// File: rtl/lcg_bit_packer.sv
// Discards a warm-up run of generator bits, then packs bits MSB-first into
// words buffered in a FIFO. Define PACKER_REPCNT_EN to add the run-length health check.
module lcg_bit_packer
    import lcg_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int WARMUP_BITS = 8,
    parameter int RUN_LIMIT   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          bit_in,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          overflow,
    output logic [clog2(FIFO_DEPTH):0]    fill_level,
    output logic                          health_fail
);
    localparam int     CNT_W   = clog2(WORD_W);
    localparam int     WU_W    = (WARMUP_BITS < 2) ? 1 : clog2(WARMUP_BITS);
    localparam state_t ST_INIT = (WARMUP_BITS == 0) ? ST_PACK : ST_WARMUP;

    state_t            state_q, state_d;
    logic              wu_sample, pack_sample;
    logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d, push_word;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              overflow_q, overflow_d;
    logic              word_done, push_req, discard;
    logic              fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // PACK is terminal until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_WARMUP && en && wu_cnt_q == WU_W'(WARMUP_BITS - 1))
            state_d = ST_PACK;
    end

    always_comb begin
        wu_sample   = 1'b0;
        pack_sample = 1'b0;
        case (state_q)
            ST_WARMUP: wu_sample   = en;
            ST_PACK:   pack_sample = en;
            default:   ;
        endcase
    end

    assign push_word = {shreg_q[WORD_W-2:0], bit_in};
    assign word_done = pack_sample && (bit_cnt_q == CNT_W'(WORD_W - 1));

`ifdef PACKER_REPCNT_EN
    localparam int RUN_W = clog2(RUN_LIMIT + 1);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             last_bit_q, health_q, health_d, rep_trip;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (pack_sample) begin
            if (run_cnt_q != '0 && bit_in == last_bit_q) begin
                if (run_cnt_q != RUN_W'(RUN_LIMIT)) run_cnt_d = run_cnt_q + 1'b1;
            end else begin
                run_cnt_d = RUN_W'(1);
            end
        end
        rep_trip = pack_sample && !health_q && (run_cnt_d == RUN_W'(RUN_LIMIT));
        health_d = health_q | rep_trip;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            health_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            if (pack_sample) last_bit_q <= bit_in;
            health_q <= health_d;
        end
    end

    // the tripping sample also kills any word it would have completed
    assign discard     = rep_trip;
    assign push_req    = word_done && !health_q && !rep_trip;
    assign health_fail = health_q;
`else
    logic [31:0] unused_run_limit;
    assign unused_run_limit = RUN_LIMIT;
    assign discard          = 1'b0;
    assign push_req         = word_done;
    assign health_fail      = 1'b0;
`endif

    always_comb begin
        wu_cnt_d  = wu_cnt_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (wu_sample) wu_cnt_d = wu_cnt_q + 1'b1;
        if (pack_sample) begin
            shreg_d   = push_word;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
        end
        if (discard) bit_cnt_d = '0;
        overflow_d = overflow_q | (push_req & fifo_full & ~word_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wu_cnt_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wu_cnt_q   <= wu_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    lcg_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_req),
        .push_data_i (push_word),
        .pop_i       (word_ready),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .fill_o      (fill_level),
        .head_o      (word_out)
    );

    assign word_valid = ~fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lcg_bit_packer.sv
// Scoreboard bench for lcg_bit_packer: an 8-bit instance for packing/FIFO
// behaviour and a 32-bit instance for the run-length health check.
module tb_lcg_bit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       reset = 1'b1, en = 1'b0, bit_in = 1'b0, word_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid, overflow, health_fail;
    logic [2:0] fill_level;

    // 32-bit instance
    logic        reset32 = 1'b1, en32 = 1'b0, bit32 = 1'b0, ready32 = 1'b0;
    logic [31:0] out32;
    logic        valid32, ovf32, hf32;
    logic [2:0]  fill32;

    lcg_bit_packer #(.WORD_W(8), .FIFO_DEPTH(4), .WARMUP_BITS(8), .RUN_LIMIT(32)) dut (
        .clk(clk), .reset(reset), .en(en), .bit_in(bit_in),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .fill_level(fill_level), .health_fail(health_fail)
    );

    lcg_bit_packer #(.WORD_W(32), .FIFO_DEPTH(4), .WARMUP_BITS(8), .RUN_LIMIT(32)) dut32 (
        .clk(clk), .reset(reset32), .en(en32), .bit_in(bit32),
        .word_out(out32), .word_valid(valid32), .word_ready(ready32),
        .overflow(ovf32), .fill_level(fill32), .health_fail(hf32)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp32_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitors: a pop happens on the edge after a cycle with valid & ready
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL word8: got %0h expected no word", word_out);
            end else begin
                check("word8", word_out, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset32 && valid32 && ready32) begin
            if (exp32_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL word32: got %0h expected no word", out32);
            end else begin
                check("word32", out32, exp32_q.pop_front());
            end
        end
    end

    task automatic drive(input logic b, input logic e);
        bit_in = b; en = e;
        @(posedge clk); #1;
    endtask

    task automatic drive32(input logic b, input logic e);
        bit32 = b; en32 = e;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic warmup(input logic b);
        for (int i = 0; i < 8; i++) drive(b, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] w, input bit expect_it);
        if (expect_it) exp_q.push_back(w);
        for (int i = 7; i >= 0; i--) drive(w[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    logic [7:0]  w8;
    logic [31:0] w32;

    initial begin
        // reset values
        do_reset();
        check("rst_word_out", word_out, 0);
        check("rst_valid", word_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fill", fill_level, 0);
        check("rst_health", health_fail, 0);

        // warm-up discard and latency
        word_ready = 1'b1;
        warmup(1'b1);
        w8 = 8'hA5;
        exp_q.push_back(w8);
        for (int i = 7; i >= 0; i--) begin
            drive(w8[i], 1'b1);
            if (i > 0) check("valid_early", word_valid, 0);
            else       check("valid_latency", word_valid, 1);
        end
        idle(3);
        check("t1_drained", exp_q.size(), 0);
        check("t1_valid_low", word_valid, 0);

        // en toggling: bits offered with en=0 are inverted and must be ignored
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1);
            drive(1'b0, 1'b0);
        end
        exp_q.push_back(w8);
        for (int i = 7; i >= 0; i--) begin
            drive(w8[i], 1'b1);
            drive(~w8[i], 1'b0);
        end
        idle(3);
        check("t2_drained", exp_q.size(), 0);

        // backpressure and overflow
        do_reset();
        word_ready = 1'b0;
        warmup(1'b0);
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1);
        check("t3_fill_4", fill_level, 4);
        check("t3_no_ovf_yet", overflow, 0);
        send_byte(8'h05, 1'b0);
        check("t3_fill_full", fill_level, 4);
        check("t3_head", word_out, 8'h01);
        check("t3_overflow", overflow, 1);
        check("t3_valid", word_valid, 1);
        word_ready = 1'b1;
        idle(6);
        check("t3_fill_empty", fill_level, 0);
        check("t3_valid_low", word_valid, 0);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_drained", exp_q.size(), 0);

        // full FIFO with push and pop on the same edge
        do_reset();
        word_ready = 1'b0;
        warmup(1'b1);
        for (int k = 8'h11; k <= 8'h14; k++) send_byte(8'(k), 1'b1);
        w8 = 8'h15;
        exp_q.push_back(w8);
        for (int i = 7; i >= 1; i--) drive(w8[i], 1'b1);
        word_ready = 1'b1;
        drive(w8[0], 1'b1);
        check("t4_fill_stays", fill_level, 4);
        check("t4_no_overflow", overflow, 0);
        idle(6);
        check("t4_fill_empty", fill_level, 0);
        check("t4_drained", exp_q.size(), 0);
        check("t4_overflow_end", overflow, 0);

        // reset mid-word flushes FIFO and partial word
        do_reset();
        word_ready = 1'b0;
        warmup(1'b1);
        send_byte(8'h3C, 1'b0);
        drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1);
        drive(1'b1, 1'b1); drive(1'b0, 1'b1);
        check("t5_pre_valid", word_valid, 1);
        do_reset();
        check("t5_word_out", word_out, 0);
        check("t5_valid", word_valid, 0);
        check("t5_fill", fill_level, 0);
        check("t5_overflow", overflow, 0);
        word_ready = 1'b1;
        warmup(1'b0);
        check("t5_no_word_in_warmup", word_valid, 0);
        send_byte(8'h96, 1'b1);
        idle(3);
        check("t5_drained", exp_q.size(), 0);

        // run-length health check on the 32-bit instance
        repeat (2) @(posedge clk);
        #1 reset32 = 1'b0;
        ready32 = 1'b0;
        for (int i = 0; i < 8; i++) drive32(1'b1, 1'b1);
        w32 = 32'hA5A5_A5A5;
        exp32_q.push_back(w32);
        for (int i = 31; i >= 0; i--) drive32(w32[i], 1'b1);
        check("t6_fill_1", fill32, 1);
`ifndef PACKER_REPCNT_EN
        exp32_q.push_back(32'h0);
`endif
        for (int i = 0; i < 31; i++) drive32(1'b0, 1'b1);
        check("t6_hf_before", hf32, 0);
        drive32(1'b0, 1'b1);
`ifdef PACKER_REPCNT_EN
        check("t6_hf_trip", hf32, 1);
        check("t6_no_push", fill32, 1);
`else
        check("t6_hf_off", hf32, 0);
        check("t6_zero_pushed", fill32, 2);
`endif
        for (int i = 0; i < 8; i++) drive32(1'b0, 1'b1);
`ifdef PACKER_REPCNT_EN
        check("t6_hf_sticky", hf32, 1);
`else
        check("t6_hf_still_off", hf32, 0);
`endif
        ready32 = 1'b1;
        for (int i = 0; i < 5; i++) drive32(1'b0, 1'b0);
        check("t6_fill_empty", fill32, 0);
        check("t6_drained", exp32_q.size(), 0);
        check("t6_no_overflow", ovf32, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
